jtag_gpio_top: RTL and testbench

- Chip-level top: a clk-domain-oversampled IEEE 1149.1 TAP that gives JTAG access to three LED outputs and one active-low button input.
- Instructions: IDCODE (default after reset), GPIO (4'ha), BYPASS.
- tck/tms/tdi are treated as data and sampled in the clk domain; no logic is clocked by tck.

---
 rtl/jtag_gpio_top.sv | 223 ++++++++++++++++++++++
 tb/tb_jtag_gpio_top.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/jtag_gpio_top.sv
// rtl/jtag_gpio_top.sv - clk-oversampled JTAG TAP giving scan access to three LEDs and a button.
// Define JTAG_TAP_GENERIC_EN to expose tck/tms/tdi/tdo; otherwise the TAP is tied idle in TLR.

module jtag_gpio_tap #(
   parameter int          IR_LENGTH    = 4,
   parameter logic [31:0] IDCODE_VALUE = 32'h149511C3,
   parameter logic [3:0]  IR_IDCODE    = 4'h2,
   parameter logic [3:0]  IR_GPIO      = 4'hA,
   parameter logic [3:0]  IR_BYPASS    = 4'hF
) (
   input  logic clk,
   input  logic reset_,
   input  logic tck,
   input  logic tms,
   input  logic tdi,
   output logic tdo,
   output logic led0,
   output logic led1,
   output logic led2,
   input  logic button_
);

   typedef enum logic [3:0] {
      TLR      = 4'd0,
      RTI      = 4'd1,
      SEL_DR   = 4'd2,
      CAP_DR   = 4'd3,
      SHIFT_DR = 4'd4,
      EXIT1_DR = 4'd5,
      PAUSE_DR = 4'd6,
      EXIT2_DR = 4'd7,
      UPD_DR   = 4'd8,
      SEL_IR   = 4'd9,
      CAP_IR   = 4'd10,
      SHIFT_IR = 4'd11,
      EXIT1_IR = 4'd12,
      PAUSE_IR = 4'd13,
      EXIT2_IR = 4'd14,
      UPD_IR   = 4'd15
   } tap_state_t;

   tap_state_t tap_state, tap_next;

   logic [1:0] tck_sync, tms_sync, tdi_sync, btn_sync;
   logic       tck_prev;
   logic       tck_rise, tms_s, tdi_s;

   logic [IR_LENGTH-1:0] ir, ir_sr;
   logic [31:0]          idcode_sr;
   logic [3:0]           gpio_sr;
   logic                 bypass_sr;
   logic [2:0]           leds;
   logic                 sel_idcode, sel_gpio, sel_bypass;
   logic                 dr_lsb, tdo_next;

   assign tms_s    = tms_sync[1];
   assign tdi_s    = tdi_sync[1];
   assign tck_rise = tck_sync[1] & ~tck_prev;

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         tck_sync <= 2'b00;
         tms_sync <= 2'b00;
         tdi_sync <= 2'b00;
         btn_sync <= 2'b00;
         tck_prev <= 1'b0;
      end else begin
         tck_sync <= {tck_sync[0], tck};
         tms_sync <= {tms_sync[0], tms};
         tdi_sync <= {tdi_sync[0], tdi};
         btn_sync <= {btn_sync[0], button_};
         tck_prev <= tck_sync[1];
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) tap_state <= TLR;
      else         tap_state <= tap_next;
   end

   always_comb begin
      tap_next = tap_state;
      if (tck_rise) begin
         case (tap_state)
            TLR:      tap_next = tms_s ? TLR      : RTI;
            RTI:      tap_next = tms_s ? SEL_DR   : RTI;
            SEL_DR:   tap_next = tms_s ? SEL_IR   : CAP_DR;
            CAP_DR:   tap_next = tms_s ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: tap_next = tms_s ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: tap_next = tms_s ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: tap_next = tms_s ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: tap_next = tms_s ? UPD_DR   : SHIFT_DR;
            UPD_DR:   tap_next = tms_s ? SEL_DR   : RTI;
            SEL_IR:   tap_next = tms_s ? TLR      : CAP_IR;
            CAP_IR:   tap_next = tms_s ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: tap_next = tms_s ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: tap_next = tms_s ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: tap_next = tms_s ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: tap_next = tms_s ? UPD_IR   : SHIFT_IR;
            UPD_IR:   tap_next = tms_s ? SEL_DR   : RTI;
            default:  tap_next = TLR;
         endcase
      end
   end

   // Any opcode other than IDCODE or GPIO falls back to the 1-bit bypass register.
   assign sel_idcode = (ir == IR_IDCODE);
   assign sel_gpio   = (ir == IR_GPIO);
   assign sel_bypass = (ir == IR_BYPASS) || !(sel_idcode || sel_gpio);

   always_comb begin
      dr_lsb = 1'b0;
      if (sel_idcode)    dr_lsb = idcode_sr[0];
      else if (sel_gpio) dr_lsb = gpio_sr[0];
      else if (sel_bypass) dr_lsb = bypass_sr;
   end

   always_comb begin
      tdo_next = 1'b0;
      if (tap_state == SHIFT_IR)      tdo_next = ir_sr[0];
      else if (tap_state == SHIFT_DR) tdo_next = dr_lsb;
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         ir        <= IR_IDCODE;
         ir_sr     <= '0;
         idcode_sr <= '0;
         gpio_sr   <= '0;
         bypass_sr <= 1'b0;
         leds      <= 3'b000;
         tdo       <= 1'b0;
      end else begin
         if (tck_rise) begin
            case (tap_state)
               CAP_IR:   ir_sr <= IR_LENGTH'(1);
               SHIFT_IR: ir_sr <= {tdi_s, ir_sr[IR_LENGTH-1:1]};
               UPD_IR:   ir    <= ir_sr;
               CAP_DR: begin
                  if (sel_idcode)    idcode_sr <= IDCODE_VALUE;
                  else if (sel_gpio) gpio_sr   <= {btn_sync[1], leds};
                  else               bypass_sr <= 1'b0;
               end
               SHIFT_DR: begin
                  if (sel_idcode)    idcode_sr <= {tdi_s, idcode_sr[31:1]};
                  else if (sel_gpio) gpio_sr   <= {tdi_s, gpio_sr[3:1]};
                  else               bypass_sr <= tdi_s;
               end
               UPD_DR:   if (sel_gpio) leds <= gpio_sr[2:0];
               default: ;
            endcase
            if (tap_next == TLR) ir <= IR_IDCODE;
         end
         // One cycle behind the shift so a tck-edge sampler sees the pre-shift LSB.
         tdo <= tdo_next;
      end
   end

   assign led0 = leds[0];
   assign led1 = leds[1];
   assign led2 = leds[2];

endmodule

module jtag_gpio_top #(
   parameter int          IR_LENGTH    = 4,
   parameter logic [31:0] IDCODE_VALUE = 32'h149511C3,
   parameter logic [3:0]  IR_IDCODE    = 4'h2,
   parameter logic [3:0]  IR_GPIO      = 4'hA,
   parameter logic [3:0]  IR_BYPASS    = 4'hF
) (
   input  logic clk,
   input  logic reset_,
`ifdef JTAG_TAP_GENERIC_EN
   input  logic tck,
   input  logic tms,
   input  logic tdi,
   output logic tdo,
`endif
   output logic led0,
   output logic led1,
   output logic led2,
   input  logic button_
);

   logic tap_tck, tap_tms, tap_tdi;

`ifdef JTAG_TAP_GENERIC_EN
   assign tap_tck = tck;
   assign tap_tms = tms;
   assign tap_tdi = tdi;
`else
   logic unused_tdo;
   // tms held high with no tck edges keeps the TAP parked in TLR.
   assign tap_tck = 1'b0;
   assign tap_tms = 1'b1;
   assign tap_tdi = 1'b0;
`endif

   jtag_gpio_tap #(
      .IR_LENGTH   (IR_LENGTH),
      .IDCODE_VALUE(IDCODE_VALUE),
      .IR_IDCODE   (IR_IDCODE),
      .IR_GPIO     (IR_GPIO),
      .IR_BYPASS   (IR_BYPASS)
   ) u_tap (
      .clk    (clk),
      .reset_ (reset_),
      .tck    (tap_tck),
      .tms    (tap_tms),
      .tdi    (tap_tdi),
`ifdef JTAG_TAP_GENERIC_EN
      .tdo    (tdo),
`else
      .tdo    (unused_tdo),
`endif
      .led0   (led0),
      .led1   (led1),
      .led2   (led2),
      .button_(button_)
   );

endmodule

// File: tb/tb_jtag_gpio_top.sv
// tb/tb_jtag_gpio_top.sv - table-driven JTAG scan bench with a per-bit tdo scoreboard.
// Scans reach the chip top when JTAG_TAP_GENERIC_EN is defined, else the TAP core directly.

module tb_jtag_gpio_top;

   localparam logic [31:0] IDCODE = 32'h149511C3;

   logic clk = 1'b0;
   logic reset_, tck, tms, tdi, button_;
   logic top_tdo, top_led0, top_led1, top_led2;
   logic core_tdo, core_led0, core_led1, core_led2;
   logic obs_tdo;
   logic [2:0] obs_leds;

   int checks = 0;
   int errors = 0;
   logic exp_q[$];

   always #5 clk = ~clk;

   jtag_gpio_top u_dut (
      .clk    (clk),
      .reset_ (reset_),
`ifdef JTAG_TAP_GENERIC_EN
      .tck    (tck),
      .tms    (tms),
      .tdi    (tdi),
      .tdo    (top_tdo),
`endif
      .led0   (top_led0),
      .led1   (top_led1),
      .led2   (top_led2),
      .button_(button_)
   );

   jtag_gpio_tap u_core (
      .clk    (clk),
      .reset_ (reset_),
      .tck    (tck),
      .tms    (tms),
      .tdi    (tdi),
      .tdo    (core_tdo),
      .led0   (core_led0),
      .led1   (core_led1),
      .led2   (core_led2),
      .button_(button_)
   );

`ifdef JTAG_TAP_GENERIC_EN
   assign obs_tdo  = top_tdo;
   assign obs_leds = {top_led2, top_led1, top_led0};
`else
   assign top_tdo  = 1'b0;
   assign obs_tdo  = core_tdo;
   assign obs_leds = {core_led2, core_led1, core_led0};
`endif

   typedef struct {
      logic [3:0]  ir;
      logic [31:0] din;
      int          len;
      logic        btn;
      logic [31:0] exp_dr;
      logic [2:0]  exp_leds;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One full tck period: low phase with new tms/tdi, sample tdo just before the rise.
   task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic s);
      @(negedge clk);
      tck = 1'b0;
      tms = tms_v;
      tdi = tdi_v;
      repeat (4) @(negedge clk);
      s = obs_tdo;
      tck = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic tms_step(input logic tms_v);
      logic s;
      tck_cycle(tms_v, 1'b0, s);
   endtask

   // From RTI: scan len bits through IR or DR, checking tdo bit by bit, end back in RTI.
   task automatic scan(input logic is_ir, input logic [31:0] din, input int len,
                       input logic [31:0] exp, input string name);
      logic s;
      tms_step(1'b1);
      if (is_ir) tms_step(1'b1);
      tms_step(1'b0);
      tms_step(1'b0);
      for (int b = 0; b < len; b++) begin
         exp_q.push_back(exp[b]);
         tck_cycle(b == len - 1, din[b], s);
         check($sformatf("%s bit%0d", name, b), {31'd0, s}, {31'd0, exp_q.pop_front()});
      end
      tms_step(1'b1);
      tms_step(1'b0);
   endtask

   task automatic tap_reset_to_rti();
      for (int i = 0; i < 5; i++) tms_step(1'b1);
      tms_step(1'b0);
   endtask

   initial begin
      vecs[0] = '{4'hF, 32'hB2, 8,  1'b0, 32'h64,  3'b000};
      vecs[1] = '{4'hA, 32'h5,  4,  1'b0, 32'h0,   3'b101};
      vecs[2] = '{4'hA, 32'h5,  4,  1'b0, 32'h5,   3'b101};
      vecs[3] = '{4'hA, 32'h5,  4,  1'b1, 32'hD,   3'b101};
      vecs[4] = '{4'h7, 32'hB2, 8,  1'b1, 32'h64,  3'b101};
      vecs[5] = '{4'h2, 32'h0,  32, 1'b1, IDCODE,  3'b101};
      vecs[6] = '{4'hA, 32'hA,  4,  1'b1, 32'hD,   3'b010};
      vecs[7] = '{4'hA, 32'h5,  4,  1'b0, 32'h2,   3'b101};

      reset_  = 1'b0;
      tck     = 1'b0;
      tms     = 1'b1;
      tdi     = 1'b0;
      button_ = 1'b0;
      repeat (4) @(negedge clk);
      check("reset tdo", {31'd0, obs_tdo}, 32'd0);
      check("reset leds", {29'd0, obs_leds}, 32'd0);
      check("reset tap state", 32'(u_core.tap_state), 32'd0);
      check("reset ir", {28'd0, u_core.ir}, 32'h2);
      reset_ = 1'b1;
      repeat (4) @(negedge clk);

      tap_reset_to_rti();
      scan(1'b0, 32'd0, 32, IDCODE, "idcode default");
      check("idcode sr drained", u_core.idcode_sr, 32'd0);

      for (int i = 0; i < 8; i++) begin
         button_ = ~vecs[i].btn;
         button_ = vecs[i].btn;
         scan(1'b1, {28'd0, vecs[i].ir}, 4, 32'h1, $sformatf("v%0d ir", i));
         scan(1'b0, vecs[i].din, vecs[i].len, vecs[i].exp_dr, $sformatf("v%0d dr", i));
         check($sformatf("v%0d leds", i), {29'd0, obs_leds}, {29'd0, vecs[i].exp_leds});
`ifndef JTAG_TAP_GENERIC_EN
         check($sformatf("v%0d top leds tied", i), {29'd0, top_led2, top_led1, top_led0}, 32'd0);
`endif
      end

      for (int i = 0; i < 5; i++) tms_step(1'b1);
      check("tlr keeps leds", {29'd0, obs_leds}, 32'h5);
      check("tlr ir idcode", {28'd0, u_core.ir}, 32'h2);
      tms_step(1'b0);
      scan(1'b0, 32'd0, 32, IDCODE, "idcode after tlr");

      scan(1'b1, 32'hA, 4, 32'h1, "abort ir");
      begin
         logic s;
         tms_step(1'b1);
         tms_step(1'b0);
         tms_step(1'b0);
         tck_cycle(1'b0, 1'b1, s);
         tck_cycle(1'b0, 1'b0, s);
      end
      @(negedge clk);
      reset_ = 1'b0;
      #1;
      check("abort leds", {29'd0, obs_leds}, 32'd0);
      check("abort tdo", {31'd0, obs_tdo}, 32'd0);
      check("abort tap state", 32'(u_core.tap_state), 32'd0);
      tck = 1'b0;
      tms = 1'b1;
      repeat (3) @(negedge clk);
      reset_ = 1'b1;
      repeat (3) @(negedge clk);
      tms_step(1'b0);
      scan(1'b0, 32'd0, 32, IDCODE, "idcode after abort");
      check("leds after abort", {29'd0, obs_leds}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
